// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulation controller: 3:2 folds each operand into (s, c),
// then resolves the pair CHUNK bits per cycle into a binary result.
module csa_accum_ctrl #(
    parameter int W     = 32,
    parameter int EXT   = 4,
    parameter int CHUNK = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W+EXT-1:0] out_data,
    output logic [EXT:0]    out_count,
    output logic            out_ovf
);

    localparam int OW  = W + EXT;
    localparam int NCH = (OW + CHUNK - 1) / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [EXT:0] LIM = {1'b1, {EXT{1'b0}}};

    typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

    state_t          state, state_n;
    logic [OW-1:0]   s, c, res, res_n, x, maj;
    logic [EXT:0]    cnt;
    logic            cin;
    logic [KW-1:0]   k;
    logic [CHUNK-1:0] s_ch, c_ch;
    logic [CHUNK:0]  ch_sum;
    logic            acc_fire, last_ch;
    int              sh;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_data  = res;
    assign out_count = cnt;
    assign out_ovf   = (cnt > LIM);

    assign acc_fire = in_valid && (state == ACCUM);
    assign last_ch  = (k == KW'(NCH - 1));
    assign x        = OW'(in_data);
    assign maj      = (s & c) | (s & x) | (c & x);

    // Bits shifted past OW fall off, which truncates the top chunk and
    // drops its carry-out.
    always_comb begin
        sh     = int'(k) * CHUNK;
        s_ch   = CHUNK'(s >> sh);
        c_ch   = CHUNK'(c >> sh);
        ch_sum = {1'b0, s_ch} + {1'b0, c_ch} + {{CHUNK{1'b0}}, cin};
        res_n  = (res & ~(OW'({CHUNK{1'b1}}) << sh))
               | (OW'(ch_sum[CHUNK-1:0]) << sh);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ACCUM:   if (acc_fire && in_last) state_n = RESOLVE;
            RESOLVE: if (last_ch) state_n = DONE;
            DONE:    if (out_ready) state_n = ACCUM;
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= '0;
            c   <= '0;
            res <= '0;
            cnt <= '0;
            cin <= 1'b0;
            k   <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (acc_fire) begin
                        s <= s ^ c ^ x;
                        c <= {maj[OW-2:0], 1'b0};
                        if (cnt != '1) cnt <= cnt + 1'b1;
                        if (in_last) begin
                            k   <= '0;
                            cin <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    res <= res_n;
                    cin <= ch_sum[CHUNK];
                    k   <= k + 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        s   <= '0;
                        c   <= '0;
                        cnt <= '0;
                        res <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
